// File: rtl/sysserv_status_monitor.sv
// Tracks system-services commands from start to completion, flags hangs, and
// drives stretched busy/ok/error LEDs plus saturating debug counters.
module sysserv_status_monitor #(
   parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
   parameter int unsigned LED_HOLD_CYCLES = 12_500_000,
   parameter int unsigned CNT_WIDTH       = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 usr_busy,
   input  logic                 usr_cmd_error,
   input  logic                 usr_rdvld,
   input  logic                 clear_counts,
   output logic                 led_busy,
   output logic                 led_ok,
   output logic                 led_error,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] cmd_count,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic [7:0]           rdvld_count
);

   localparam int unsigned BUSY_W = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned HOLD_W = (LED_HOLD_CYCLES > 1) ? $clog2(LED_HOLD_CYCLES) : 1;
   localparam logic [BUSY_W-1:0]    BUSY_LAST = BUSY_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(LED_HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY,
      ST_TIMEOUT,
      ST_HOLD_OK,
      ST_HOLD_ERR
   } state_e;

   state_e               state_q, state_d;
   logic [BUSY_W-1:0]    busy_cnt_q, busy_cnt_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                 err_seen_q, err_seen_d;
   logic                 timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0] cmd_count_q, cmd_count_d;
   logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
   logic [7:0]           rdvld_count_q, rdvld_count_d;
   logic                 led_busy_q, led_busy_d;
   logic                 led_ok_q, led_ok_d;
   logic                 led_error_q, led_error_d;
   logic                 start_cmd;
   logic                 cmd_inc;
   logic                 err_inc;
   logic                 rdvld_inc;

   // Next-state, counter and LED logic; LEDs are decoded from the next state
   // so they appear on the same edge the state changes.
   always_comb begin
      state_d       = state_q;
      busy_cnt_d    = busy_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      err_seen_d    = err_seen_q;
      timeout_d     = timeout_q;
      cmd_count_d   = cmd_count_q;
      err_count_d   = err_count_q;
      rdvld_count_d = rdvld_count_q;
      start_cmd     = 1'b0;
      cmd_inc       = 1'b0;
      err_inc       = 1'b0;
      rdvld_inc     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            start_cmd = usr_busy;
         end
         ST_BUSY: begin
            rdvld_inc  = usr_rdvld;
            err_seen_d = err_seen_q | usr_cmd_error;
            if (!usr_busy) begin
               cmd_inc    = 1'b1;
               hold_cnt_d = '0;
               if (err_seen_q | usr_cmd_error) begin
                  err_inc = 1'b1;
                  state_d = ST_HOLD_ERR;
               end else begin
                  state_d = ST_HOLD_OK;
               end
            end else if (busy_cnt_q == BUSY_LAST) begin
               state_d   = ST_TIMEOUT;
               timeout_d = 1'b1;
               err_inc   = 1'b1;
            end else begin
               busy_cnt_d = busy_cnt_q + BUSY_W'(1);
            end
         end
         ST_TIMEOUT: begin
            rdvld_inc = usr_rdvld;
            if (!usr_busy) begin
               cmd_inc    = 1'b1;
               hold_cnt_d = '0;
               state_d    = ST_HOLD_ERR;
            end
         end
         ST_HOLD_OK, ST_HOLD_ERR: begin
            if (usr_busy) begin
               start_cmd = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_cmd) begin
         state_d       = ST_BUSY;
         busy_cnt_d    = '0;
         rdvld_count_d = '0;
         err_seen_d    = usr_cmd_error;
      end

      if (rdvld_inc && (rdvld_count_q != 8'hFF)) begin
         rdvld_count_d = rdvld_count_q + 8'd1;
      end
      if (cmd_inc && (cmd_count_q != CNT_MAX)) begin
         cmd_count_d = cmd_count_q + CNT_WIDTH'(1);
      end
      if (err_inc && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + CNT_WIDTH'(1);
      end

      // Clear wins over any same-cycle increment
      if (clear_counts) begin
         cmd_count_d = '0;
         err_count_d = '0;
         timeout_d   = 1'b0;
      end

      led_busy_d  = (state_d == ST_BUSY) || (state_d == ST_TIMEOUT);
      led_ok_d    = (state_d == ST_HOLD_OK);
      led_error_d = (state_d == ST_HOLD_ERR) || (state_d == ST_TIMEOUT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         busy_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         err_seen_q    <= 1'b0;
         timeout_q     <= 1'b0;
         cmd_count_q   <= '0;
         err_count_q   <= '0;
         rdvld_count_q <= '0;
         led_busy_q    <= 1'b0;
         led_ok_q      <= 1'b0;
         led_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_cnt_q    <= busy_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         err_seen_q    <= err_seen_d;
         timeout_q     <= timeout_d;
         cmd_count_q   <= cmd_count_d;
         err_count_q   <= err_count_d;
         rdvld_count_q <= rdvld_count_d;
         led_busy_q    <= led_busy_d;
         led_ok_q      <= led_ok_d;
         led_error_q   <= led_error_d;
      end
   end

   assign led_busy    = led_busy_q;
   assign led_ok      = led_ok_q;
   assign led_error   = led_error_q;
   assign timeout     = timeout_q;
   assign cmd_count   = cmd_count_q;
   assign err_count   = err_count_q;
   assign rdvld_count = rdvld_count_q;

endmodule

// File: tb/tb_sysserv_status_monitor.sv
// Bench for sysserv_status_monitor: vector table, directed corner sequences,
// then random traffic against a command-level reference model.
module tb_sysserv_status_monitor;

   localparam int unsigned T_CYC = 16;
   localparam int unsigned L_CYC = 4;
   localparam int unsigned CW    = 8;
   localparam int          CMAX  = 255;

   logic          clock = 1'b0;
   logic          rst, busy, cmd_err, rdvld, clr;
   logic          led_busy, led_ok, led_error, timeout;
   logic [CW-1:0] cmd_count, err_count;
   logic [7:0]    rdvld_count;

   int n_checks = 0;
   int n_pass   = 0;

   sysserv_status_monitor #(
      .TIMEOUT_CYCLES (T_CYC),
      .LED_HOLD_CYCLES(L_CYC),
      .CNT_WIDTH      (CW)
   ) dut (
      .clock        (clock),
      .reset        (rst),
      .usr_busy     (busy),
      .usr_cmd_error(cmd_err),
      .usr_rdvld    (rdvld),
      .clear_counts (clr),
      .led_busy     (led_busy),
      .led_ok       (led_ok),
      .led_error    (led_error),
      .timeout      (timeout),
      .cmd_count    (cmd_count),
      .err_count    (err_count),
      .rdvld_count  (rdvld_count)
   );

   always #5 clock = ~clock;

   // Reference model: a command is either active or not; a finished command
   // leaves an LED lit for a number of remaining cycles.
   int m_active, m_age, m_err, m_timed, m_hold, m_hold_err;
   int m_cmd, m_errc, m_to, m_rd;

   task automatic m_step();
      if (rst) begin
         m_active = 0; m_age = 0; m_err = 0; m_timed = 0; m_hold = 0; m_hold_err = 0;
         m_cmd = 0; m_errc = 0; m_to = 0; m_rd = 0;
         return;
      end
      if (m_active == 0) begin
         if (busy) begin
            m_active = 1; m_age = 0; m_rd = 0; m_err = int'(cmd_err); m_timed = 0; m_hold = 0;
         end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
         end
      end else begin
         if (rdvld && m_rd < 255) m_rd = m_rd + 1;
         if (cmd_err) m_err = 1;
         if (!busy) begin
            m_active = 0;
            if (m_cmd < CMAX) m_cmd = m_cmd + 1;
            if (m_timed == 0 && m_err != 0 && m_errc < CMAX) m_errc = m_errc + 1;
            m_hold_err = (m_timed != 0 || m_err != 0) ? 1 : 0;
            m_hold = L_CYC;
         end else begin
            m_age = m_age + 1;
            if (m_age == T_CYC && m_timed == 0) begin
               m_timed = 1;
               m_to = 1;
               if (m_errc < CMAX) m_errc = m_errc + 1;
            end
         end
      end
      if (clr) begin
         m_cmd = 0; m_errc = 0; m_to = 0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_all(input string tag, input int lb, input int ok, input int le,
                          input int to, input int cmd, input int errc, input int rd);
      chk({tag, ".led_busy"},    int'(led_busy),    lb);
      chk({tag, ".led_ok"},      int'(led_ok),      ok);
      chk({tag, ".led_error"},   int'(led_error),   le);
      chk({tag, ".timeout"},     int'(timeout),     to);
      chk({tag, ".cmd_count"},   int'(cmd_count),   cmd);
      chk({tag, ".err_count"},   int'(err_count),   errc);
      chk({tag, ".rdvld_count"}, int'(rdvld_count), rd);
   endtask

   task automatic drive(input logic b, input logic e, input logic r, input logic c, input logic rs);
      busy = b; cmd_err = e; rdvld = r; clr = c; rst = rs;
   endtask

   // One clock: model consumes the same inputs the DUT samples, then settle.
   task automatic tick();
      m_step();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic b, e, r, c, rs;
      int   lb, ok, le, to, cmd, errc, rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic b, input logic e, input logic r, input logic c, input logic rs,
                      input int lb, input int ok, input int le, input int to,
                      input int cmd, input int errc, input int rd);
      vec_t v;
      v.b = b; v.e = e; v.r = r; v.c = c; v.rs = rs;
      v.lb = lb; v.ok = ok; v.le = le; v.to = to; v.cmd = cmd; v.errc = errc; v.rd = rd;
      vecs.push_back(v);
   endtask

   initial begin
      drive(0, 0, 0, 0, 1);

      // busy err rdv clr rst | lb ok le to cmd errc rd
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // clean command: 5 busy samples, 3 rdvld pulses
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
      add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
      // error command: 6 busy samples, error pulse in cycle 2
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      // error sampled together with busy falling
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].b, vecs[i].e, vecs[i].r, vecs[i].c, vecs[i].rs);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].lb, vecs[i].ok, vecs[i].le, vecs[i].to,
                 vecs[i].cmd, vecs[i].errc, vecs[i].rd);
      end

      // Hang: busy held for 40 samples
      drive(0, 0, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 0); tick();
      chk_all("hang.start", 1, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k < 40; k++) begin
         tick();
         chk($sformatf("hang.timeout@%0d", k), int'(timeout), (k >= 16) ? 1 : 0);
         chk($sformatf("hang.led_error@%0d", k), int'(led_error), (k >= 16) ? 1 : 0);
      end
      chk_all("hang.held", 1, 0, 1, 1, 0, 1, 0);
      drive(0, 0, 0, 0, 0); tick();
      chk_all("hang.done", 0, 0, 1, 1, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("hang.hold%0d", k), 0, 0, 1, 1, 1, 1, 0);
      end
      tick();
      chk_all("hang.idle", 0, 0, 0, 1, 1, 1, 0);

      // Saturation, then clear coincident with a timed-out completion
      drive(0, 0, 0, 0, 1); tick();
      for (int i = 1; i <= 260; i++) begin
         drive(1, 0, 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0); tick();
         if (i == 1 || i == 255 || i == 260)
            chk($sformatf("sat.cmd_count@%0d", i), int'(cmd_count), (i > 255) ? 255 : i);
      end
      drive(1, 0, 0, 0, 0);
      repeat (17) tick();
      chk_all("sat.timed", 1, 0, 1, 1, 255, 1, 0);
      drive(0, 0, 0, 1, 0); tick();
      chk_all("sat.clear", 0, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0); tick();

      // Back-to-back: new command in 2nd hold cycle
      drive(0, 0, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 0); tick();
      drive(1, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
      chk_all("b2b.first", 0, 1, 0, 0, 1, 0, 1);
      tick();
      chk_all("b2b.hold1", 0, 1, 0, 0, 1, 0, 1);
      drive(1, 0, 0, 0, 0); tick();
      chk_all("b2b.restart", 1, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0); tick();
      chk_all("b2b.second", 0, 1, 0, 0, 2, 0, 0);

      // Reset during BUSY cycle 3
      drive(0, 0, 0, 0, 1); tick();
      drive(1, 0, 1, 0, 0); tick(); tick(); tick();
      chk_all("rstmid.busy", 1, 0, 0, 0, 0, 0, 2);
      drive(1, 0, 0, 0, 1); tick();
      chk_all("rstmid.reset", 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
      chk_all("rstmid.after", 0, 1, 0, 0, 1, 0, 0);

      // Random traffic against the reference model
      drive(0, 0, 0, 0, 1); tick();
      for (int seg = 0; seg < 60; seg++) begin
         int unsigned flip;
         case (seg % 3)
            0: flip = 2;
            1: flip = 8;
            default: flip = 40;
         endcase
         for (int c = 0; c < 60; c++) begin
            logic nb;
            nb = ($urandom_range(flip - 1) == 0) ? ~busy : busy;
            drive(nb,
                  ($urandom_range(9) == 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(49) == 0),
                  ($urandom_range(399) == 0));
            tick();
            chk_all("rand", m_active,
                    (m_active == 0 && m_hold > 0 && m_hold_err == 0) ? 1 : 0,
                    ((m_active != 0 && m_timed != 0) ||
                     (m_active == 0 && m_hold > 0 && m_hold_err != 0)) ? 1 : 0,
                    m_to, m_cmd, m_errc, m_rd);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
